// File: rtl/axil_pkg.sv
// rtl/axil_pkg.sv - shared AXI-Lite response codes and command master FSM states
package axil_pkg;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } resp_t;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WR     = 3'd1,
        WAIT_B = 3'd2,
        RD     = 3'd3,
        WAIT_R = 3'd4,
        RSP    = 3'd5
    } state_t;

endpackage

// File: rtl/axil_master_cmd.sv
// rtl/axil_master_cmd.sv - command/response stream to single AXI-Lite transaction master
module axil_master_cmd
    import axil_pkg::*;
#(
    parameter int AXI_DATA_WIDTH = 32,
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int ERR_CNT_WIDTH  = 8
) (
    input  logic                          aclk,
    input  logic                          aresetn,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic                          cmd_we,
    input  logic [AXI_ADDR_WIDTH-1:0]     cmd_addr,
    input  logic [AXI_DATA_WIDTH-1:0]     cmd_wdata,
    input  logic [AXI_DATA_WIDTH/8-1:0]   cmd_wstrb,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic                          rsp_we,
    output logic [AXI_DATA_WIDTH-1:0]     rsp_rdata,
    output logic [1:0]                    rsp_resp,
    output logic [AXI_ADDR_WIDTH-1:0]     m_axil_awaddr,
    output logic [2:0]                    m_axil_awprot,
    output logic                          m_axil_awvalid,
    input  logic                          m_axil_awready,
    output logic [AXI_DATA_WIDTH-1:0]     m_axil_wdata,
    output logic [AXI_DATA_WIDTH/8-1:0]   m_axil_wstrb,
    output logic                          m_axil_wvalid,
    input  logic                          m_axil_wready,
    input  logic [1:0]                    m_axil_bresp,
    input  logic                          m_axil_bvalid,
    output logic                          m_axil_bready,
    output logic [AXI_ADDR_WIDTH-1:0]     m_axil_araddr,
    output logic [2:0]                    m_axil_arprot,
    output logic                          m_axil_arvalid,
    input  logic                          m_axil_arready,
    input  logic [AXI_DATA_WIDTH-1:0]     m_axil_rdata,
    input  logic [1:0]                    m_axil_rresp,
    input  logic                          m_axil_rvalid,
    output logic                          m_axil_rready,
    output logic [ERR_CNT_WIDTH-1:0]      err_cnt,
    output logic                          timeout_flag,
    input  logic                          err_clr
);

    localparam int WD_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
    localparam logic [ERR_CNT_WIDTH-1:0] ERR_MAX = '1;

    state_t          state;
    logic [WD_W-1:0] wd_cnt;
    logic            busy;
    logic            err_inc;
    logic            aw_next;
    logic            w_next;

    assign m_axil_awprot = 3'b000;
    assign m_axil_arprot = 3'b000;

    always_comb begin
        busy    = state inside {WR, WAIT_B, RD, WAIT_R};
        err_inc = ((state == WAIT_B) && m_axil_bvalid && (m_axil_bresp != OKAY)) ||
                  ((state == WAIT_R) && m_axil_rvalid && (m_axil_rresp != OKAY));
        // A channel stays valid only while its own handshake is still outstanding.
        aw_next = m_axil_awvalid && !m_axil_awready;
        w_next  = m_axil_wvalid && !m_axil_wready;
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state          <= IDLE;
            cmd_ready      <= 1'b0;
            rsp_valid      <= 1'b0;
            rsp_we         <= 1'b0;
            rsp_rdata      <= '0;
            rsp_resp       <= 2'b00;
            m_axil_awaddr  <= '0;
            m_axil_awvalid <= 1'b0;
            m_axil_wdata   <= '0;
            m_axil_wstrb   <= '0;
            m_axil_wvalid  <= 1'b0;
            m_axil_bready  <= 1'b0;
            m_axil_araddr  <= '0;
            m_axil_arvalid <= 1'b0;
            m_axil_rready  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    cmd_ready <= 1'b1;
                    if (cmd_valid && cmd_ready) begin
                        cmd_ready <= 1'b0;
                        rsp_we    <= cmd_we;
                        if (cmd_we) begin
                            m_axil_awaddr  <= cmd_addr;
                            m_axil_wdata   <= cmd_wdata;
                            m_axil_wstrb   <= cmd_wstrb;
                            m_axil_awvalid <= 1'b1;
                            m_axil_wvalid  <= 1'b1;
                            state          <= WR;
                        end else begin
                            m_axil_araddr  <= cmd_addr;
                            m_axil_arvalid <= 1'b1;
                            state          <= RD;
                        end
                    end
                end
                WR: begin
                    m_axil_awvalid <= aw_next;
                    m_axil_wvalid  <= w_next;
                    if (!aw_next && !w_next) begin
                        m_axil_bready <= 1'b1;
                        state         <= WAIT_B;
                    end
                end
                WAIT_B: begin
                    if (m_axil_bvalid) begin
                        m_axil_bready <= 1'b0;
                        rsp_resp      <= m_axil_bresp;
                        rsp_rdata     <= '0;
                        rsp_valid     <= 1'b1;
                        state         <= RSP;
                    end
                end
                RD: begin
                    if (m_axil_arready) begin
                        m_axil_arvalid <= 1'b0;
                        m_axil_rready  <= 1'b1;
                        state          <= WAIT_R;
                    end
                end
                WAIT_R: begin
                    if (m_axil_rvalid) begin
                        m_axil_rready <= 1'b0;
                        rsp_rdata     <= m_axil_rdata;
                        rsp_resp      <= m_axil_rresp;
                        rsp_valid     <= 1'b1;
                        state         <= RSP;
                    end
                end
                RSP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Watchdog only flags; a stuck transaction keeps waiting since a valid cannot be withdrawn.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wd_cnt       <= '0;
            timeout_flag <= 1'b0;
            err_cnt      <= '0;
        end else begin
            if (state == IDLE) begin
                wd_cnt <= '0;
            end else if (busy && (wd_cnt != WD_LAST)) begin
                wd_cnt <= wd_cnt + 1'b1;
            end

            if (err_clr) begin
                timeout_flag <= 1'b0;
            end else if (busy && (wd_cnt == WD_LAST)) begin
                timeout_flag <= 1'b1;
            end

            if (err_clr) begin
                err_cnt <= '0;
            end else if (err_inc && (err_cnt != ERR_MAX)) begin
                err_cnt <= err_cnt + 1'b1;
            end
        end
    end

endmodule
